// File: rtl/seq_pkg.sv
// Shared definitions for the machine-cycle / T-state sequencer.
// Holds the FSM state type, the M/T widths and the one-hot constants
// used by mt_sequencer and seq_wait_ctrl.
package seq_pkg;

    // Sequencer modes: normal T-state stepping, wait-state hold, bus granted.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } seq_state_e;

    localparam int NUM_M = 5;
    localparam int NUM_T = 6;

    // Bit positions inside the one-hot M and T vectors.
    localparam int M1_B = 0;
    localparam int T1_B = 0;
    localparam int T2_B = 1;

    // One-hot constants sized to NUM_M / NUM_T above.
    localparam logic [NUM_M-1:0] M1_OH  = 5'b00001;
    localparam logic [NUM_T-1:0] T1_OH  = 6'b000001;
    localparam logic [NUM_T-1:0] T3_OH  = 6'b000100;
    localparam logic [NUM_T-1:0] T_NONE = 6'b000000;

    // Successor of a one-hot M vector; the last legal M cycle wraps to M1.
    function automatic logic [NUM_M-1:0] nextMState(input logic [NUM_M-1:0] cur,
                                                   input int              maxM);
        logic [NUM_M-1:0] res;
        res = cur << 1;
        if (cur[maxM-1]) begin
            res = M1_OH;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_wait_ctrl.sv
// Wait-state decision for the sequencer: says whether the current T2 or Tw
// should be held (next cycle is Tw) or allowed to advance to T3.
// Optional feature macro: SEQ_IO_AUTOWAIT_EN -- when defined, an I/O cycle
// always gets one automatic wait state after T2, regardless of the WAIT pin.
module seq_wait_ctrl
    import seq_pkg::*;
(
    input  logic i_inT2,
    input  logic i_inTw,
    input  logic i_waitIn,
    input  logic i_ioCycle,
    output logic o_hold
);

    logic w_t2Hold;

`ifdef SEQ_IO_AUTOWAIT_EN
    // An I/O cycle forces the first Tw; from that Tw onward only WAIT matters.
    always_comb begin
        w_t2Hold = i_waitIn | i_ioCycle;
    end
`else
    logic w_unused_ioCycle;

    // Without auto-wait, T2 is held only by the WAIT pin; io_cycle is inert.
    always_comb begin
        w_t2Hold         = i_waitIn;
        w_unused_ioCycle = i_ioCycle;
    end
`endif

    // WAIT is only meaningful in T2 and Tw; every other T state ignores it.
    always_comb begin
        o_hold = 1'b0;
        if (i_inTw) begin
            o_hold = i_waitIn;
        end else if (i_inT2) begin
            o_hold = w_t2Hold;
        end
    end

endmodule

// File: rtl/mt_sequencer.sv
// Machine-cycle / T-state sequencer for the CPU control path.
// Produces one-hot M1..M5 and T1..T6, inserts wait states, handles the
// bus request/grant handshake and flags T-state overruns.
// Optional feature macro: SEQ_IO_AUTOWAIT_EN (handled in seq_wait_ctrl).
module mt_sequencer
    import seq_pkg::*;
#(
    parameter int MAX_T = 6,
    parameter int MAX_M = 5
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             next_m,
    input  logic             set_m1,
    input  logic             wait_in,
    input  logic             io_cycle,
    input  logic             busrq,
    output logic [NUM_M-1:0] m_state,
    output logic [NUM_T-1:0] t_state,
    output logic             tw,
    output logic             busack,
    output logic             seq_err
);

    seq_state_e       r_fsm;
    logic [NUM_M-1:0] r_mState;
    logic [NUM_T-1:0] r_tState;
    logic             r_tw;
    logic             r_busack;
    logic             r_seqErr;

    seq_state_e       w_fsmNext;
    logic [NUM_M-1:0] w_mNext;
    logic [NUM_T-1:0] w_tNext;
    logic             w_twNext;
    logic             w_busackNext;
    logic             w_errNext;

    logic             w_inT2;
    logic             w_inTw;
    logic             w_hold;
    logic             w_endReq;
    logic             w_endWindow;
    logic             w_atLastT;
    logic [NUM_M-1:0] w_targetM;

    assign w_inT2 = (r_fsm == RUN) && r_tState[T2_B];
    assign w_inTw = (r_fsm == WAIT);

    seq_wait_ctrl u_waitCtrl (
        .i_inT2    (w_inT2),
        .i_inTw    (w_inTw),
        .i_waitIn  (wait_in),
        .i_ioCycle (io_cycle),
        .o_hold    (w_hold)
    );

    // End-of-cycle qualification: only T3..T(MAX_T) may close an M cycle,
    // set_m1 beats next_m, and an overrun at T(MAX_T) falls back to M1.
    always_comb begin
        w_endReq    = set_m1 | next_m;
        w_endWindow = |r_tState[MAX_T-1:2];
        w_atLastT   = r_tState[MAX_T-1];
        w_targetM   = M1_OH;
        if (!set_m1 && next_m) begin
            w_targetM = nextMState(r_mState, MAX_M);
        end
    end

    // Next-state logic for the RUN / WAIT / GRANT modes and the M/T vectors.
    always_comb begin
        w_fsmNext    = r_fsm;
        w_mNext      = r_mState;
        w_tNext      = r_tState;
        w_twNext     = 1'b0;
        w_busackNext = 1'b0;
        w_errNext    = 1'b0;
        case (r_fsm)
            RUN: begin
                if (r_tState[T2_B]) begin
                    if (w_hold) begin
                        w_fsmNext = WAIT;
                        w_twNext  = 1'b1;
                    end else begin
                        w_tNext = T3_OH;
                    end
                end else if (w_endWindow && (w_endReq || w_atLastT)) begin
                    w_mNext   = w_targetM;
                    w_errNext = ~w_endReq;
                    if (busrq) begin
                        w_fsmNext    = GRANT;
                        w_tNext      = T_NONE;
                        w_busackNext = 1'b1;
                    end else begin
                        w_tNext = T1_OH;
                    end
                end else begin
                    w_tNext = r_tState << 1;
                end
            end
            WAIT: begin
                if (w_hold) begin
                    w_twNext = 1'b1;
                end else begin
                    w_fsmNext = RUN;
                    w_tNext   = T3_OH;
                end
            end
            GRANT: begin
                if (busrq) begin
                    w_busackNext = 1'b1;
                end else begin
                    w_fsmNext = RUN;
                    w_tNext   = T1_OH;
                end
            end
            default: begin
                w_fsmNext = RUN;
                w_mNext   = M1_OH;
                w_tNext   = T1_OH;
            end
        endcase
    end

    // State and output registers; reset overrides waits and bus grant alike.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm    <= RUN;
            r_mState <= M1_OH;
            r_tState <= T1_OH;
            r_tw     <= 1'b0;
            r_busack <= 1'b0;
            r_seqErr <= 1'b0;
        end else begin
            r_fsm    <= w_fsmNext;
            r_mState <= w_mNext;
            r_tState <= w_tNext;
            r_tw     <= w_twNext;
            r_busack <= w_busackNext;
            r_seqErr <= w_errNext;
        end
    end

    assign m_state = r_mState;
    assign t_state = r_tState;
    assign tw      = r_tw;
    assign busack  = r_busack;
    assign seq_err = r_seqErr;

endmodule

// File: tb/tb_mt_sequencer.sv
// Self-checking bench for mt_sequencer: directed scenarios followed by
// randomized traffic. A driver pushes the expected registered outputs from
// an integer-level model into a queue; a monitor pops and compares them.
// Honours SEQ_IO_AUTOWAIT_EN in the model when the build defines it.
module tb_mt_sequencer;

    typedef struct {
        logic [4:0] m;
        logic [5:0] t;
        logic       tw;
        logic       busack;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       next_m;
    logic       set_m1;
    logic       wait_in;
    logic       io_cycle;
    logic       busrq;
    logic [4:0] m_state;
    logic [5:0] t_state;
    logic       tw;
    logic       busack;
    logic       seq_err;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: M number 1..5, T number 1..6, mode 0=run 1=wait 2=grant.
    int   modelM    = 1;
    int   modelT    = 1;
    int   modelMode = 0;
    bit   modelErr  = 1'b0;

    mt_sequencer #(.MAX_T(6), .MAX_M(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .next_m   (next_m),
        .set_m1   (set_m1),
        .wait_in  (wait_in),
        .io_cycle (io_cycle),
        .busrq    (busrq),
        .m_state  (m_state),
        .t_state  (t_state),
        .tw       (tw),
        .busack   (busack),
        .seq_err  (seq_err)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the behavioural model by one clock edge given the sampled inputs.
    task automatic modelStep(input bit rst, input bit nm, input bit s1,
                             input bit wi, input bit io, input bit br);
        bit hold;
        bit ends;
        if (rst) begin
            modelM = 1; modelT = 1; modelMode = 0; modelErr = 1'b0;
            return;
        end
        modelErr = 1'b0;
        if (modelMode == 0) begin
            if (modelT == 2) begin
                hold = wi;
`ifdef SEQ_IO_AUTOWAIT_EN
                hold = wi || io;
`endif
                if (hold) modelMode = 1;
                else      modelT = 3;
            end else if (modelT >= 3) begin
                ends = nm || s1;
                if (ends || modelT == 6) begin
                    if (s1)      modelM = 1;
                    else if (nm) modelM = (modelM == 5) ? 1 : modelM + 1;
                    else         modelM = 1;
                    modelErr = !ends;
                    if (br) modelMode = 2;
                    modelT = 1;
                end else begin
                    modelT = modelT + 1;
                end
            end else begin
                modelT = modelT + 1;
            end
        end else if (modelMode == 1) begin
            if (!wi) begin
                modelMode = 0;
                modelT = 3;
            end
        end else begin
            if (!br) begin
                modelMode = 0;
                modelT = 1;
            end
        end
    endtask

    function automatic exp_t modelExpected();
        exp_t e;
        e.m      = 5'(1 << (modelM - 1));
        e.t      = (modelMode == 2) ? 6'd0 : 6'(1 << (modelT - 1));
        e.tw     = (modelMode == 1);
        e.busack = (modelMode == 2);
        e.err    = modelErr;
        return e;
    endfunction

    // Drive one cycle of inputs, queue the expected result, move to next negedge.
    task automatic applyStimulus(input bit rst, input bit nm, input bit s1,
                                 input bit wi, input bit io, input bit br);
        reset    = rst;
        next_m   = nm;
        set_m1   = s1;
        wait_in  = wi;
        io_cycle = io;
        busrq    = br;
        modelStep(rst, nm, s1, wi, io, br);
        expQ.push_back(modelExpected());
        @(negedge clk);
    endtask

    // Step until the model reaches M(tm)/T(tt) in RUN, using next_m at T3.
    task automatic goTo(input int tm, input int tt);
        int guard;
        bit nm;
        guard = 0;
        while (!(modelMode == 0 && modelM == tm && modelT == tt) && guard < 200) begin
            nm = (modelMode == 0 && modelT >= 3 && modelM != tm);
            applyStimulus(1'b0, nm, 1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("[TB] FAIL goTo: reached M%0d/T%0d mode %0d, required M%0d/T%0d",
                     modelM, modelT, modelMode, tm, tt);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare one edge's worth at a time.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("m_state", {3'b0, m_state}, {3'b0, e.m});
                checkOutput("t_state", {2'b0, t_state}, {2'b0, e.t});
                checkOutput("tw",      {7'b0, tw},      {7'b0, e.tw});
                checkOutput("busack",  {7'b0, busack},  {7'b0, e.busack});
                checkOutput("seq_err", {7'b0, seq_err}, {7'b0, e.err});
            end
        end
    end

    // Directed scenarios, then randomized traffic, then drain and summarise.
    initial begin
        int drain;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        goTo(1, 4);
        applyStimulus(0, 1, 0, 0, 0, 0);

        goTo(2, 2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        goTo(3, 3);
        applyStimulus(0, 1, 1, 0, 0, 0);
        goTo(5, 3);
        applyStimulus(0, 1, 0, 0, 0, 0);

        goTo(2, 3);
        applyStimulus(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        goTo(3, 6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        goTo(1, 2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        goTo(2, 3);
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);

        goTo(1, 2);
        applyStimulus(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(3) == 0),
                          ($urandom_range(7) == 0),
                          ($urandom_range(2) == 0),
                          ($urandom_range(2) == 0),
                          ($urandom_range(5) != 0 && busack) || ($urandom_range(5) == 0));
        end

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            #2;
            drain++;
        end
        checks++;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
